y86_decode_stage: RTL and testbench

- Parametrised decode/writeback stage for the pipelined Y86-64 core; successor of the single-cycle decode block.
- Holds the register file and derives srcA/srcB/dstE/dstM from icode/rA/rB.
- Registers all results into the D→E pipeline register, with stall/bubble control and dual writeback ports (E and M).

---
 rtl/y86_pkg.sv | 40 ++++
 rtl/y86_regfile.sv | 76 +++++++
 rtl/y86_decode_stage.sv | 141 ++++++++++++++
 tb/tb_y86_decode_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 decode/writeback stage.
//   - icode constants
//   - RNONE, the "no register" index
//   - default stack-pointer index
//   - d2e_t: control fields of the D->E pipeline register
// The data words (valC/valA/valB) are kept out of d2e_t because their width
// follows the DATA_W parameter of the instantiating module.
package y86_pkg;

   localparam logic [3:0] I_HALT  = 4'h0;
   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_CMOV  = 4'h2;
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_CALL  = 4'h8;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_PUSH  = 4'hA;
   localparam logic [3:0] I_POP   = 4'hB;

   localparam logic [3:0] RNONE       = 4'hF;
   localparam int         RSP_IDX_DEF = 4;

   typedef struct packed {
      logic       valid;
      logic [3:0] icode;
      logic [3:0] ifun;
      logic [3:0] src_a;
      logic [3:0] src_b;
      logic [3:0] dst_e;
      logic [3:0] dst_m;
   } d2e_t;

   localparam d2e_t D2E_NOP = '{valid: 1'b0, icode: I_NOP, ifun: 4'h0,
                                src_a: RNONE, src_b: RNONE,
                                dst_e: RNONE, dst_m: RNONE};

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: NREGS x DATA_W, two async read ports, two write
// ports (E and M). When both write ports target the same register, M wins.
// Indices equal to 0xF or >= NREGS read as 0 and are never written.
// Optional macro Y86_REGFILE_BYPASS_EN: reads matching a same-cycle write
// return the write data (M before E) instead of the stored contents.
// Ports:
//   clk, rst                  clock, async active-high reset (clears all regs)
//   rd_a_idx/rd_a_data        read port A
//   rd_b_idx/rd_b_data        read port B
//   wr_e_idx/wr_e_data        write port E
//   wr_m_idx/wr_m_data        write port M (priority)
//   reg_flat                  register i at [i*DATA_W +: DATA_W]
module y86_regfile
   import y86_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int NREGS  = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3:0]              rd_a_idx,
   output logic [DATA_W-1:0]       rd_a_data,
   input  logic [3:0]              rd_b_idx,
   output logic [DATA_W-1:0]       rd_b_data,
   input  logic [3:0]              wr_e_idx,
   input  logic [DATA_W-1:0]       wr_e_data,
   input  logic [3:0]              wr_m_idx,
   input  logic [DATA_W-1:0]       wr_m_data,
   output logic [NREGS*DATA_W-1:0] reg_flat
);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic              wr_e_ok;
   logic              wr_m_ok;

   assign wr_e_ok = (wr_e_idx != RNONE) && (int'(wr_e_idx) < NREGS);
   assign wr_m_ok = (wr_m_idx != RNONE) && (int'(wr_m_idx) < NREGS);

   // M is applied after E so it overrides on a collision (popq %rsp).
   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < NREGS; i++) begin
         if (wr_e_ok && int'(wr_e_idx) == i) regs_d[i] = wr_e_data;
         if (wr_m_ok && int'(wr_m_idx) == i) regs_d[i] = wr_m_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rd_a_data = '0;
      rd_b_data = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (rd_a_idx != RNONE && int'(rd_a_idx) == i) rd_a_data = regs_q[i];
         if (rd_b_idx != RNONE && int'(rd_b_idx) == i) rd_b_data = regs_q[i];
      end
`ifdef Y86_REGFILE_BYPASS_EN
      if (wr_e_ok && rd_a_idx == wr_e_idx) rd_a_data = wr_e_data;
      if (wr_m_ok && rd_a_idx == wr_m_idx) rd_a_data = wr_m_data;
      if (wr_e_ok && rd_b_idx == wr_e_idx) rd_b_data = wr_e_data;
      if (wr_m_ok && rd_b_idx == wr_m_idx) rd_b_data = wr_m_data;
`endif
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_flat
      assign reg_flat[g*DATA_W +: DATA_W] = regs_q[g];
   end

endmodule

// File: rtl/y86_decode_stage.sv
// Decode/writeback stage of the pipelined Y86-64 core.
// Derives srcA/srcB/dstE/dstM from icode/rA/rB, reads the register file and
// registers the result into the D->E pipeline register (priority
// e_bubble > e_stall > load). Writeback ports E and M update the register
// file every posedge regardless of stall/bubble.
// Optional macro Y86_REGFILE_BYPASS_EN (in y86_regfile): same-cycle writes
// are forwarded into the values being decoded.
// Ports:
//   clk, rst                         clock, async active-high reset
//   d_valid/d_icode/d_ifun/d_rA/d_rB/d_valC/d_valP   decode inputs
//   e_stall, e_bubble                E register control
//   w_dstE/w_valE, w_dstM/w_valM     writeback ports
//   e_*                              D->E pipeline register outputs
//   reg_flat                         register dump
module y86_decode_stage
   import y86_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int NREGS   = 15,
   parameter int RSP_IDX = RSP_IDX_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    d_valid,
   input  logic [3:0]              d_icode,
   input  logic [3:0]              d_ifun,
   input  logic [3:0]              d_rA,
   input  logic [3:0]              d_rB,
   input  logic [DATA_W-1:0]       d_valC,
   input  logic [DATA_W-1:0]       d_valP,
   input  logic                    e_stall,
   input  logic                    e_bubble,
   input  logic [3:0]              w_dstE,
   input  logic [DATA_W-1:0]       w_valE,
   input  logic [3:0]              w_dstM,
   input  logic [DATA_W-1:0]       w_valM,
   output logic                    e_valid,
   output logic [3:0]              e_icode,
   output logic [3:0]              e_ifun,
   output logic [DATA_W-1:0]       e_valC,
   output logic [DATA_W-1:0]       e_valA,
   output logic [DATA_W-1:0]       e_valB,
   output logic [3:0]              e_srcA,
   output logic [3:0]              e_srcB,
   output logic [3:0]              e_dstE,
   output logic [3:0]              e_dstM,
   output logic [NREGS*DATA_W-1:0] reg_flat
);

   localparam logic [3:0] RSP = 4'(RSP_IDX);

   logic [3:0]        src_a, src_b, dst_e, dst_m;
   logic [DATA_W-1:0] rd_a, rd_b;
   d2e_t              ctl_d, ctl_q;
   logic [DATA_W-1:0] valc_d, valc_q, vala_d, vala_q, valb_d, valb_q;

   always_comb begin
      case (d_icode)
         I_CMOV, I_RMMOV, I_OPQ, I_PUSH: src_a = d_rA;
         I_RET, I_POP:                   src_a = RSP;
         default:                        src_a = RNONE;
      endcase
      case (d_icode)
         I_RMMOV, I_MRMOV, I_OPQ:        src_b = d_rB;
         I_CALL, I_RET, I_PUSH, I_POP:   src_b = RSP;
         default:                        src_b = RNONE;
      endcase
      // cmov always names rB; execute squashes the write when !Cnd.
      case (d_icode)
         I_CMOV, I_IRMOV, I_OPQ:         dst_e = d_rB;
         I_CALL, I_RET, I_PUSH, I_POP:   dst_e = RSP;
         default:                        dst_e = RNONE;
      endcase
      case (d_icode)
         I_MRMOV, I_POP:                 dst_m = d_rA;
         default:                        dst_m = RNONE;
      endcase
   end

   y86_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rd_a_idx  (src_a),
      .rd_a_data (rd_a),
      .rd_b_idx  (src_b),
      .rd_b_data (rd_b),
      .wr_e_idx  (w_dstE),
      .wr_e_data (w_valE),
      .wr_m_idx  (w_dstM),
      .wr_m_data (w_valM),
      .reg_flat  (reg_flat)
   );

   always_comb begin
      ctl_d  = ctl_q;
      valc_d = valc_q;
      vala_d = vala_q;
      valb_d = valb_q;
      if (e_bubble || (!e_stall && !d_valid)) begin
         ctl_d  = D2E_NOP;
         valc_d = '0;
         vala_d = '0;
         valb_d = '0;
      end else if (!e_stall) begin
         ctl_d  = '{valid: 1'b1, icode: d_icode, ifun: d_ifun,
                    src_a: src_a, src_b: src_b, dst_e: dst_e, dst_m: dst_m};
         valc_d = d_valC;
         vala_d = (d_icode == I_JXX || d_icode == I_CALL) ? d_valP : rd_a;
         valb_d = rd_b;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctl_q  <= D2E_NOP;
         valc_q <= '0;
         vala_q <= '0;
         valb_q <= '0;
      end else begin
         ctl_q  <= ctl_d;
         valc_q <= valc_d;
         vala_q <= vala_d;
         valb_q <= valb_d;
      end
   end

   assign e_valid = ctl_q.valid;
   assign e_icode = ctl_q.icode;
   assign e_ifun  = ctl_q.ifun;
   assign e_srcA  = ctl_q.src_a;
   assign e_srcB  = ctl_q.src_b;
   assign e_dstE  = ctl_q.dst_e;
   assign e_dstM  = ctl_q.dst_m;
   assign e_valC  = valc_q;
   assign e_valA  = vala_q;
   assign e_valB  = valb_q;

endmodule

// File: tb/tb_y86_decode_stage.sv
// Directed bench for y86_decode_stage with an expected-result queue.
module tb_y86_decode_stage;
   import y86_pkg::*;

   localparam int DW = 64;
   localparam int NR = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          d_valid;
   logic [3:0]    d_icode, d_ifun, d_rA, d_rB;
   logic [DW-1:0] d_valC, d_valP;
   logic          e_stall, e_bubble;
   logic [3:0]    w_dstE, w_dstM;
   logic [DW-1:0] w_valE, w_valM;
   logic          e_valid;
   logic [3:0]    e_icode, e_ifun, e_srcA, e_srcB, e_dstE, e_dstM;
   logic [DW-1:0] e_valC, e_valA, e_valB;
   logic [NR*DW-1:0] reg_flat;

   y86_decode_stage #(.DATA_W(DW), .NREGS(NR), .RSP_IDX(4)) dut (
      .clk(clk), .rst(rst),
      .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun),
      .d_rA(d_rA), .d_rB(d_rB), .d_valC(d_valC), .d_valP(d_valP),
      .e_stall(e_stall), .e_bubble(e_bubble),
      .w_dstE(w_dstE), .w_valE(w_valE), .w_dstM(w_dstM), .w_valM(w_valM),
      .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
      .e_valC(e_valC), .e_valA(e_valA), .e_valB(e_valB),
      .e_srcA(e_srcA), .e_srcB(e_srcB), .e_dstE(e_dstE), .e_dstM(e_dstM),
      .reg_flat(reg_flat)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          valid;
      logic [3:0]    icode, ifun, src_a, src_b, dst_e, dst_m;
      logic [DW-1:0] valc, vala, valb;
   } exp_t;

   exp_t          sb_q[$];
   string         tag_q[$];
   logic [DW-1:0] regs_m [NR];
   int            n_vec = 0;
   int            n_bad = 0;

`ifdef Y86_REGFILE_BYPASS_EN
   localparam logic [DW-1:0] BYP_VALA = 64'd9;
`else
   localparam logic [DW-1:0] BYP_VALA = 64'd0;
`endif

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [DW-1:0] vc, input logic [DW-1:0] va, input logic [DW-1:0] vb,
                       input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] de,
                       input logic [3:0] dm);
      exp_t e;
      e.valid = v;  e.icode = ic; e.ifun = fn;
      e.valc  = vc; e.vala  = va; e.valb = vb;
      e.src_a = sa; e.src_b = sb; e.dst_e = de; e.dst_m = dm;
      sb_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic push_nop(input string tag);
      push(tag, 1'b0, I_NOP, 4'h0, '0, '0, '0, RNONE, RNONE, RNONE, RNONE);
   endtask

   task automatic check_e();
      exp_t  e;
      string t;
      if (sb_q.size() == 0) begin
         n_vec++;
         n_bad++;
         $error("FAIL scoreboard: observed empty queue expected an entry");
         return;
      end
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".valid"}, DW'(e_valid), DW'(e.valid));
      chk({t, ".icode"}, DW'(e_icode), DW'(e.icode));
      chk({t, ".ifun"},  DW'(e_ifun),  DW'(e.ifun));
      chk({t, ".valC"},  e_valC, e.valc);
      chk({t, ".valA"},  e_valA, e.vala);
      chk({t, ".valB"},  e_valB, e.valb);
      chk({t, ".srcA"},  DW'(e_srcA), DW'(e.src_a));
      chk({t, ".srcB"},  DW'(e_srcB), DW'(e.src_b));
      chk({t, ".dstE"},  DW'(e_dstE), DW'(e.dst_e));
      chk({t, ".dstM"},  DW'(e_dstM), DW'(e.dst_m));
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NR; i++)
         chk($sformatf("%s.r%0d", tag, i), reg_flat[i*DW +: DW], regs_m[i]);
   endtask

   task automatic dec(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [3:0] ra, input logic [3:0] rb,
                      input logic [DW-1:0] vc, input logic [DW-1:0] vp);
      d_valid = v; d_icode = ic; d_ifun = fn; d_rA = ra; d_rB = rb;
      d_valC = vc; d_valP = vp;
   endtask

   task automatic wb(input logic [3:0] de, input logic [DW-1:0] ve,
                     input logic [3:0] dm, input logic [DW-1:0] vm);
      w_dstE = de; w_valE = ve; w_dstM = dm; w_valM = vm;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NR; i++) regs_m[i] = '0;
      rst = 1'b1; e_stall = 1'b0; e_bubble = 1'b0;
      dec(1'b0, I_NOP, 4'h0, RNONE, RNONE, '0, '0);
      wb(RNONE, '0, RNONE, '0);
      tick(); tick();
      push_nop("reset");
      check_e();
      check_regs("reset");
      rst = 1'b0;

      // write r3 = 5
      wb(4'd3, 64'd5, RNONE, '0);
      push_nop("idle_a");
      tick(); check_e();
      regs_m[3] = 64'd5;
      check_regs("wr3");

      // OPq rA=2 rB=3
      wb(RNONE, '0, RNONE, '0);
      dec(1'b1, I_OPQ, 4'h0, 4'd2, 4'd3, 64'h1234, 64'h40);
      push("opq", 1'b1, I_OPQ, 4'h0, 64'h1234, 64'd0, 64'd5, 4'd2, 4'd3, 4'd3, RNONE);
      tick(); check_e();

      // dual write collision on r4: M wins
      wb(4'd4, 64'd100, 4'd4, 64'd200);
      dec(1'b0, I_NOP, 4'h0, RNONE, RNONE, '0, '0);
      push_nop("idle_c");
      tick(); check_e();
      regs_m[4] = 64'd200;
      check_regs("collide");

      // popq rA=5
      wb(RNONE, '0, RNONE, '0);
      dec(1'b1, I_POP, 4'h0, 4'd5, RNONE, '0, 64'h12);
      push("popq", 1'b1, I_POP, 4'h0, 64'd0, 64'd200, 64'd200, 4'd4, 4'd4, 4'd4, 4'd5);
      tick(); check_e();

      // call: valA = valP
      dec(1'b1, I_CALL, 4'h0, RNONE, RNONE, 64'h100, 64'h26);
      push("call", 1'b1, I_CALL, 4'h0, 64'h100, 64'h26, 64'd200, RNONE, 4'd4, 4'd4, RNONE);
      tick(); check_e();

      // irmovq, then stall with a new input
      dec(1'b1, I_IRMOV, 4'h0, RNONE, 4'd7, 64'hABCD, 64'h30);
      push("irmov", 1'b1, I_IRMOV, 4'h0, 64'hABCD, 64'd0, 64'd0, RNONE, RNONE, 4'd7, RNONE);
      tick(); check_e();
      e_stall = 1'b1;
      dec(1'b1, I_OPQ, 4'h1, 4'd3, 4'd4, 64'h99, 64'h40);
      push("stall", 1'b1, I_IRMOV, 4'h0, 64'hABCD, 64'd0, 64'd0, RNONE, RNONE, 4'd7, RNONE);
      tick(); check_e();
      e_bubble = 1'b1;
      push_nop("stall_bubble");
      tick(); check_e();
      e_stall = 1'b0;
      push_nop("bubble");
      tick(); check_e();
      e_bubble = 1'b0;
      dec(1'b0, I_OPQ, 4'h0, 4'd3, 4'd4, 64'h5, 64'h6);
      push_nop("invalid");
      tick(); check_e();

      // rrmovq rA=2 rB=6 while writing r2 = 9 on port M
      wb(RNONE, '0, 4'd2, 64'd9);
      dec(1'b1, I_CMOV, 4'h0, 4'd2, 4'd6, '0, 64'h50);
      push("rrmov_byp", 1'b1, I_CMOV, 4'h0, 64'd0, BYP_VALA, 64'd0, 4'd2, RNONE, 4'd6, RNONE);
      tick(); check_e();
      regs_m[2] = 64'd9;
      check_regs("wr2");

      // writes to index F are ignored
      wb(RNONE, 64'h77, RNONE, 64'h88);
      dec(1'b0, I_NOP, 4'h0, RNONE, RNONE, '0, '0);
      push_nop("idle_f");
      tick(); check_e();
      check_regs("wrF");

      // independent writes on both ports
      wb(4'd0, 64'h11, 4'd1, 64'h55);
      push_nop("idle_2w");
      tick(); check_e();
      regs_m[0] = 64'h11;
      regs_m[1] = 64'h55;
      check_regs("wr01");

      wb(RNONE, '0, RNONE, '0);
      dec(1'b1, I_RET, 4'h0, RNONE, RNONE, '0, 64'h60);
      push("ret", 1'b1, I_RET, 4'h0, 64'd0, 64'd200, 64'd200, 4'd4, 4'd4, 4'd4, RNONE);
      tick(); check_e();
      dec(1'b1, I_JXX, 4'h3, RNONE, RNONE, 64'h80, 64'h44);
      push("jxx", 1'b1, I_JXX, 4'h3, 64'h80, 64'h44, 64'd0, RNONE, RNONE, RNONE, RNONE);
      tick(); check_e();
      dec(1'b1, I_MRMOV, 4'h0, 4'd7, 4'd2, 64'h8, 64'h4A);
      push("mrmov", 1'b1, I_MRMOV, 4'h0, 64'h8, 64'd0, 64'd9, RNONE, 4'd2, RNONE, 4'd7);
      tick(); check_e();
      dec(1'b1, I_RMMOV, 4'h0, 4'd1, 4'd3, 64'h18, 64'h54);
      push("rmmov", 1'b1, I_RMMOV, 4'h0, 64'h18, 64'h55, 64'd5, 4'd1, 4'd3, RNONE, RNONE);
      tick(); check_e();
      dec(1'b1, I_PUSH, 4'h0, 4'd3, RNONE, '0, 64'h70);
      push("pushq", 1'b1, I_PUSH, 4'h0, 64'd0, 64'd5, 64'd200, 4'd3, 4'd4, 4'd4, RNONE);
      tick(); check_e();

      // async reset between edges, with a write in flight
      wb(4'd2, 64'hEE, RNONE, '0);
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < NR; i++) regs_m[i] = '0;
      push_nop("async_rst");
      check_e();
      check_regs("async_rst");
      tick();
      check_regs("rst_hold");
      rst = 1'b0;
      wb(RNONE, '0, RNONE, '0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
